// File: rtl/rl_ram_1rw_pipe.sv
// ---------------------------------------------------------------------------
// rl_ram_1rw_pipe -- pipelined single-port (1RW) RAM with request/valid
// handshake, programmable read latency and post-reset array clear.
//
// Optional feature macro: RL_RAM_1RW_PARITY_EN
//   defined   : a second rl_ram_1rw holds even parity per byte lane; reads
//               report lane parity mismatches on parity_err_o.
//   undefined : no parity storage, parity_err_o is constant 0.
//   The port list is identical in both builds.
//
// Ports (rl_ram_1rw_pipe):
//   clk_i         in   1       clock, rising edge
//   rst_ni        in   1       synchronous active-low reset
//   req_i         in   1       access request
//   we_i          in   1       1 = write, 0 = read (sampled with req_i)
//   addr_i        in   ABITS   word address
//   be_i          in   NBYTES  byte enables (writes only)
//   din_i         in   DBITS   write data
//   ready_o       out  1       block accepts requests
//   dout_o        out  DBITS   read data, meaningful while dout_valid_o = 1
//   dout_valid_o  out  1       one-cycle pulse per completed read
//   parity_err_o  out  1       parity mismatch on the read being returned
//
// Ports (rl_ram_1rw, generic behavioural macro):
//   clk_i, we_i, addr_i, be_i (one bit per LANE_BITS lane), din_i,
//   dout_o (registered read, read-before-write).
// ---------------------------------------------------------------------------

module rl_ram_1rw #(
  parameter int    ABITS      = 10,
  parameter int    DBITS      = 32,
  parameter int    LANE_BITS  = 8,
  parameter int    NLANES     = (DBITS + LANE_BITS - 1) / LANE_BITS,
  parameter string TECHNOLOGY = "GENERIC",
  parameter string INIT_FILE  = ""
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ABITS-1:0]  addr_i,
  input  logic [NLANES-1:0] be_i,
  input  logic [DBITS-1:0]  din_i,
  output logic [DBITS-1:0]  dout_o
);
  // Storage is padded to whole lanes so every lane is a uniform slice.
  localparam int PBITS = NLANES * LANE_BITS;

  generate
    if (TECHNOLOGY == "") begin : g_bad_tech
      $fatal(1, "rl_ram_1rw: TECHNOLOGY must name a target");
    end
    // Preloading is the job of the vendor macros; this model has no loader.
    if ((INIT_FILE != "") && (TECHNOLOGY == "GENERIC")) begin : g_no_preload
      $fatal(1, "rl_ram_1rw: GENERIC model cannot preload INIT_FILE");
    end
  endgenerate

  logic [PBITS-1:0] mem_q [2**ABITS];
  logic [PBITS-1:0] din_pad;

  always_comb begin
    din_pad             = '0;
    din_pad[DBITS-1:0]  = din_i;
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < NLANES; i++) begin
        if (be_i[i]) begin
          mem_q[addr_i][i*LANE_BITS +: LANE_BITS] <= din_pad[i*LANE_BITS +: LANE_BITS];
        end
      end
    end
    dout_o <= mem_q[addr_i][DBITS-1:0];
  end
endmodule

module rl_ram_1rw_pipe #(
  parameter int    ABITS          = 10,
  parameter int    DBITS          = 32,
  parameter string TECHNOLOGY     = "GENERIC",
  parameter string INIT_FILE      = "",
  parameter int    RD_LATENCY     = 1,
  parameter int    CLEAR_ON_RESET = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_i,
  input  logic                     we_i,
  input  logic [ABITS-1:0]         addr_i,
  input  logic [(DBITS+7)/8-1:0]   be_i,
  input  logic [DBITS-1:0]         din_i,
  output logic                     ready_o,
  output logic [DBITS-1:0]         dout_o,
  output logic                     dout_valid_o,
  output logic                     parity_err_o
);
  localparam int NBYTES = (DBITS + 7) / 8;
  // A preloaded array must not be wiped after reset.
  localparam bit DO_CLEAR = (CLEAR_ON_RESET != 0) && (INIT_FILE == "");

  generate
    if ((RD_LATENCY < 1) || (RD_LATENCY > 4)) begin : g_bad_latency
      $fatal(1, "rl_ram_1rw_pipe: RD_LATENCY must be 1..4");
    end
  endgenerate

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t           state_q;
  logic [ABITS-1:0] cnt_q;
  logic             ready_q;

  logic              accept;
  logic              rd_accept;
  logic              ram_we;
  logic [ABITS-1:0]  ram_addr;
  logic [NBYTES-1:0] ram_be;
  logic [DBITS-1:0]  ram_din;
  logic [DBITS-1:0]  ram_dout;
  logic              err_s1;
  logic              err_last;

  logic [RD_LATENCY-1:0] vld_q;

  assign accept    = req_i & ready_q;
  assign rd_accept = accept & ~we_i;
  assign ready_o   = ready_q;

  // Control FSM. ready_q rises on the same edge the FSM lands in RUN when
  // leaving CLEAR, or one edge after reset when no clear is performed.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      if (DO_CLEAR) state_q <= ST_CLEAR;
      else          state_q <= ST_RUN;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (&cnt_q) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        default: begin
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Macro drive: the clear sequencer owns the port while clearing,
  // otherwise the requester does. Unaccepted requests leave we low.
  always_comb begin
    ram_we   = accept & we_i;
    ram_addr = addr_i;
    ram_be   = be_i;
    ram_din  = din_i;
    if (state_q == ST_CLEAR) begin
      ram_we   = 1'b1;
      ram_addr = cnt_q;
      ram_be   = '1;
      ram_din  = '0;
    end
  end

  rl_ram_1rw #(
    .ABITS      (ABITS),
    .DBITS      (DBITS),
    .LANE_BITS  (8),
    .TECHNOLOGY (TECHNOLOGY),
    .INIT_FILE  (INIT_FILE)
  ) u_data_ram (
    .clk_i  (clk_i),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .be_i   (ram_be),
    .din_i  (ram_din),
    .dout_o (ram_dout)
  );

`ifdef RL_RAM_1RW_PARITY_EN
  logic [NBYTES*8-1:0] wr_pad;
  logic [NBYTES*8-1:0] rd_pad;
  logic [NBYTES-1:0]   par_wr;
  logic [NBYTES-1:0]   par_calc;
  logic [NBYTES-1:0]   par_rd;

  always_comb begin
    wr_pad             = '0;
    wr_pad[DBITS-1:0]  = ram_din;
    rd_pad             = '0;
    rd_pad[DBITS-1:0]  = ram_dout;
  end

  // Even parity per lane; a cleared (all-zero) lane stores parity 0.
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane_par
    assign par_wr[gi]   = ^wr_pad[gi*8 +: 8];
    assign par_calc[gi] = ^rd_pad[gi*8 +: 8];
  end

  rl_ram_1rw #(
    .ABITS      (ABITS),
    .DBITS      (NBYTES),
    .LANE_BITS  (1),
    .TECHNOLOGY (TECHNOLOGY),
    .INIT_FILE  ("")
  ) u_par_ram (
    .clk_i  (clk_i),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .be_i   (ram_be),
    .din_i  (par_wr),
    .dout_o (par_rd)
  );

  assign err_s1 = |(par_calc ^ par_rd);
`else
  assign err_s1 = 1'b0;
`endif

  // Valid shift register: bit i set means a read reached stage i+1.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= rd_accept;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Stage 1 is the macro output register; further stages retime it.
  generate
    if (RD_LATENCY == 1) begin : g_lat1
      assign dout_o   = ram_dout;
      assign err_last = err_s1;
    end else begin : g_latn
      logic [DBITS-1:0]      data_q [RD_LATENCY-1];
      logic [RD_LATENCY-2:0] err_q;

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          for (int i = 0; i < RD_LATENCY - 1; i++) begin
            data_q[i] <= '0;
          end
          err_q <= '0;
        end else begin
          data_q[0] <= ram_dout;
          err_q[0]  <= err_s1;
          for (int i = 1; i < RD_LATENCY - 1; i++) begin
            data_q[i] <= data_q[i-1];
            err_q[i]  <= err_q[i-1];
          end
        end
      end

      assign dout_o   = data_q[RD_LATENCY-2];
      assign err_last = err_q[RD_LATENCY-2];
    end
  endgenerate

  assign dout_valid_o = vld_q[RD_LATENCY-1];
  assign parity_err_o = dout_valid_o & err_last;
endmodule
